// File: rtl/menu_scene_if.sv
// rtl/menu_scene_if.sv - scan/pixel bundle between the VGA timing source and the menu renderer
interface menu_scene_if;
    logic        enable;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [23:0] menu_RGB;
    logic [2:0]  cube_idx;
    logic        hop_done;

    modport master (
        output enable, x_cnt, y_cnt,
        input  menu_RGB, cube_idx, hop_done
    );

    modport slave (
        input  enable, x_cnt, y_cnt,
        output menu_RGB, cube_idx, hop_done
    );
endinterface

// File: rtl/menu_scene.sv
// rtl/menu_scene.sv - title screen: row of isometric cubes with an auto-hopping sprite
module menu_scene #(
    parameter int               N_CUBE    = 4,
    parameter int               N_COLORS  = 5,
    parameter logic [7:0][23:0] PALETTE   = {24'hFF00FF, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF,
                                             24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFA500},
    parameter logic [10:0]      X0        = 11'd150,
    parameter logic [9:0]       Y0        = 10'd110,
    parameter logic [10:0]      HALF_X    = 11'd40,
    parameter logic [9:0]       HALF_Y    = 10'd50,
    parameter logic [10:0]      SIDE      = 11'd100,
    parameter logic [10:0]      QH        = 11'd30,
    parameter logic [9:0]       QW        = 10'd24,
    parameter logic [31:0]      IDLE_CYC  = 32'd8000000,
    parameter logic [31:0]      STEP_CYC  = 32'd131072,
    parameter logic [23:0]      QBERT_RGB = 24'hFF8000,
    parameter logic [23:0]      LEFT_RGB  = 24'h404040,
    parameter logic [23:0]      RIGHT_RGB = 24'h808080,
    parameter logic [23:0]      BG_RGB    = 24'h000000
) (
    input  logic          clk,
    input  logic          reset,
    menu_scene_if.slave   bus
);

    localparam logic signed [23:0] S_X0   = $signed(24'(X0));
    localparam logic signed [23:0] S_Y0   = $signed(24'(Y0));
    localparam logic signed [23:0] S_HX   = $signed(24'(HALF_X));
    localparam logic signed [23:0] S_HY   = $signed(24'(HALF_Y));
    localparam logic signed [23:0] S_SIDE = $signed(24'(SIDE));
    localparam logic signed [23:0] S_QH   = $signed(24'(QH));
    localparam logic signed [23:0] S_QW2  = $signed(24'(QW >> 1));
    localparam logic signed [23:0] S_AREA = S_HX * S_HY;

    localparam logic [31:0] IDLE_LAST  = IDLE_CYC - 32'd1;
    localparam logic [31:0] STEP_LAST  = STEP_CYC - 32'd1;
    localparam logic [31:0] STEPS_LAST = 32'(HALF_Y) - 32'd1;
    localparam logic [2:0]  LAST_CUBE  = 3'(N_CUBE - 1);
    localparam logic [2:0]  LAST_COLOR = 3'(N_COLORS - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_LAND = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [31:0]              steps_q, steps_d;
    logic signed [23:0]       qx_q, qx_d;
    logic signed [23:0]       qy_q, qy_d;
    logic                     dir_q, dir_d;
    logic [2:0]               target_q, target_d;
    logic [2:0]               cube_idx_q, cube_idx_d;
    logic [N_CUBE-1:0][2:0]   col_q, col_d;
    logic                     hop_done_q, hop_done_d;

    logic                     spr_hit_q, spr_hit_d;
    logic                     left_hit_q, left_hit_d;
    logic                     right_hit_q, right_hit_d;
    logic [N_CUBE-1:0]        top_hit_q, top_hit_d;
    logic [23:0]              menu_rgb_q, menu_rgb_d;

    logic signed [23:0]       xs, ys;
    logic [N_CUBE-1:0]        top_hit, left_hit, right_hit;

    assign xs = $signed(24'(bus.x_cnt));
    assign ys = $signed(24'(bus.y_cnt));

    // Per-cube region tests; the diamond and side-face edges are cross-multiplied to avoid division.
    for (genvar i = 0; i < N_CUBE; i++) begin : g_cube
        localparam logic signed [23:0] CY = S_Y0 + 24'(2 * i) * S_HY;
        logic signed [23:0] dx, dyr, dy, adx, rem;
        logic               below;

        assign dx    = xs - S_X0;
        assign dyr   = ys - CY;
        assign dy    = dyr[23] ? -dyr : dyr;
        assign adx   = dx[23] ? -dx : dx;
        assign rem   = S_HX * (S_HY - dy);
        assign below = (dy <= S_HY) && (dx * S_HY > rem) && ((dx - S_SIDE) * S_HY <= rem);

        assign top_hit[i]   = (adx * S_HY + dy * S_HX) <= S_AREA;
        assign left_hit[i]  = below && dyr[23];
        assign right_hit[i] = below && !dyr[23];
    end

    always_comb begin
        spr_hit_d   = (xs >= qx_q - S_QH) && (xs < qx_q) &&
                      (ys >= qy_q - S_QW2) && (ys < qy_q + S_QW2);
        left_hit_d  = |left_hit;
        right_hit_d = |right_hit;
        top_hit_d   = top_hit;
    end

    // Descending scan so the lowest-numbered matching cube wins.
    always_comb begin
        menu_rgb_d = BG_RGB;
        if (spr_hit_q) begin
            menu_rgb_d = QBERT_RGB;
        end else if (left_hit_q) begin
            menu_rgb_d = LEFT_RGB;
        end else if (right_hit_q) begin
            menu_rgb_d = RIGHT_RGB;
        end else begin
            for (int i = N_CUBE - 1; i >= 0; i--) begin
                if (top_hit_q[i]) begin
                    menu_rgb_d = PALETTE[col_q[i]];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        steps_d    = steps_q;
        qx_d       = qx_q;
        qy_d       = qy_q;
        dir_d      = dir_q;
        target_d   = target_q;
        cube_idx_d = cube_idx_q;
        col_d      = col_q;
        hop_done_d = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (bus.enable) begin
                    if (cnt_q == IDLE_LAST) begin
                        cnt_d   = '0;
                        steps_d = '0;
                        state_d = ST_RISE;
                        if (dir_q && cube_idx_q == LAST_CUBE) begin
                            dir_d    = 1'b0;
                            target_d = cube_idx_q - 3'd1;
                        end else if (!dir_q && cube_idx_q == 3'd0) begin
                            dir_d    = 1'b1;
                            target_d = 3'd1;
                        end else if (dir_q) begin
                            target_d = cube_idx_q + 3'd1;
                        end else begin
                            target_d = cube_idx_q - 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end

            ST_RISE, ST_FALL: begin
                if (bus.enable) begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        qx_d  = (state_q == ST_RISE) ? qx_q - 24'sd1 : qx_q + 24'sd1;
                        qy_d  = dir_q ? qy_q + 24'sd1 : qy_q - 24'sd1;
                        if (steps_q == STEPS_LAST) begin
                            steps_d = '0;
                            state_d = (state_q == ST_RISE) ? ST_FALL : ST_LAND;
                        end else begin
                            steps_d = steps_q + 32'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end

            // Landing always completes, even with enable low.
            ST_LAND: begin
                cube_idx_d = target_q;
                for (int i = 0; i < N_CUBE; i++) begin
                    if (target_q == 3'(i)) begin
                        col_d[i] = (col_q[i] == LAST_COLOR) ? 3'd0 : col_q[i] + 3'd1;
                    end
                end
                hop_done_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end

            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            steps_q     <= '0;
            qx_q        <= S_X0;
            qy_q        <= S_Y0;
            dir_q       <= 1'b1;
            target_q    <= '0;
            cube_idx_q  <= '0;
            col_q       <= '0;
            hop_done_q  <= 1'b0;
            spr_hit_q   <= 1'b0;
            left_hit_q  <= 1'b0;
            right_hit_q <= 1'b0;
            top_hit_q   <= '0;
            menu_rgb_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            steps_q     <= steps_d;
            qx_q        <= qx_d;
            qy_q        <= qy_d;
            dir_q       <= dir_d;
            target_q    <= target_d;
            cube_idx_q  <= cube_idx_d;
            col_q       <= col_d;
            hop_done_q  <= hop_done_d;
            spr_hit_q   <= spr_hit_d;
            left_hit_q  <= left_hit_d;
            right_hit_q <= right_hit_d;
            top_hit_q   <= top_hit_d;
            menu_rgb_q  <= menu_rgb_d;
        end
    end

    assign bus.menu_RGB = menu_rgb_q;
    assign bus.cube_idx = cube_idx_q;
    assign bus.hop_done = hop_done_q;

endmodule
